// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem_ctrl_if : request/response bus of the data memory ctrl   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface data_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem_ctrl : byte/half/word data memory with valid/ready bus,  |
// |                 configurable latency and access error reporting   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 1,
   parameter bit SIGN_EXT_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   data_mem_ctrl_if.slave  bus
);

   localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  LAT_INIT  = 4'(LATENCY);
   localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

   localparam logic [1:0]  SZ_BYTE = 2'b00;
   localparam logic [1:0]  SZ_HALF = 2'b01;
   localparam logic [1:0]  SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;

   logic [31:0] acc_addr, acc_addr_nxt;
   logic        acc_we, acc_we_nxt;
   logic [1:0]  acc_size, acc_size_nxt;
   logic        acc_signed, acc_signed_nxt;
   logic [31:0] acc_wdata, acc_wdata_nxt;

   logic        ready_reg, ready_nxt;
   logic        rvalid_reg, rvalid_nxt;
   logic [31:0] rdata_reg, rdata_nxt;
   logic        rerr_reg, rerr_nxt;

   logic [31:0] mem [DEPTH_WORDS];

   logic [IDX_W-1:0] word_idx;
   logic [31:0]      rd_word;
   logic [31:0]      rd_shift;
   logic [31:0]      load_val;
   logic [31:0]      lane_data;
   logic [3:0]       byte_en;
   logic             acc_err;
   logic             do_ext;
   logic             mem_we;

   assign word_idx = acc_addr[IDX_W+1:2];
   assign rd_word  = mem[word_idx];
   assign rd_shift = rd_word >> {acc_addr[1:0], 3'b000};
   assign do_ext   = acc_signed && SIGN_EXT_EN;

   // Access decode works on the latched request so it is stable at commit.
   always_comb begin
      acc_err   = 1'b0;
      byte_en   = 4'b0000;
      lane_data = acc_wdata;
      load_val  = rd_word;
      case (acc_size)
         SZ_BYTE: begin
            byte_en   = 4'b0001 << acc_addr[1:0];
            lane_data = {4{acc_wdata[7:0]}};
            load_val  = {{24{do_ext & rd_shift[7]}}, rd_shift[7:0]};
         end
         SZ_HALF: begin
            acc_err   = acc_addr[0];
            byte_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{acc_wdata[15:0]}};
            load_val  = {{16{do_ext & rd_shift[15]}}, rd_shift[15:0]};
         end
         SZ_WORD: begin
            acc_err = (acc_addr[1:0] != 2'b00);
            byte_en = 4'b1111;
         end
         default: acc_err = 1'b1;
      endcase
      if ({2'b00, acc_addr[31:2]} >= DEPTH_LIM)
         acc_err = 1'b1;
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      acc_addr_nxt   = acc_addr;
      acc_we_nxt     = acc_we;
      acc_size_nxt   = acc_size;
      acc_signed_nxt = acc_signed;
      acc_wdata_nxt  = acc_wdata;
      ready_nxt      = ready_reg;
      rvalid_nxt     = rvalid_reg;
      rdata_nxt      = rdata_reg;
      rerr_nxt       = rerr_reg;
      mem_we         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               acc_addr_nxt   = bus.req_addr;
               acc_we_nxt     = bus.req_we;
               acc_size_nxt   = bus.req_size;
               acc_signed_nxt = bus.req_signed;
               acc_wdata_nxt  = bus.req_wdata;
               cnt_nxt        = LAT_INIT;
               ready_nxt      = 1'b0;
               state_nxt      = BUSY;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               mem_we     = acc_we & ~acc_err;
               rvalid_nxt = 1'b1;
               rerr_nxt   = acc_err;
               rdata_nxt  = (acc_we || acc_err) ? 32'h0 : load_val;
               state_nxt  = RESP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               rvalid_nxt = 1'b0;
               ready_nxt  = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt  = IDLE;
            ready_nxt  = 1'b1;
            rvalid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         acc_addr   <= 32'h0;
         acc_we     <= 1'b0;
         acc_size   <= 2'b00;
         acc_signed <= 1'b0;
         acc_wdata  <= 32'h0;
         ready_reg  <= 1'b1;
         rvalid_reg <= 1'b0;
         rdata_reg  <= 32'h0;
         rerr_reg   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         acc_addr   <= acc_addr_nxt;
         acc_we     <= acc_we_nxt;
         acc_size   <= acc_size_nxt;
         acc_signed <= acc_signed_nxt;
         acc_wdata  <= acc_wdata_nxt;
         ready_reg  <= ready_nxt;
         rvalid_reg <= rvalid_nxt;
         rdata_reg  <= rdata_nxt;
         rerr_reg   <= rerr_nxt;
      end
   end

   // Storage is never cleared; a store committing on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int n = 0; n < 4; n++) begin
            if (byte_en[n])
               mem[word_idx][8*n +: 8] <= lane_data[8*n +: 8];
         end
      end
   end

   assign bus.req_ready  = ready_reg;
   assign bus.resp_valid = rvalid_reg;
   assign bus.resp_rdata = rdata_reg;
   assign bus.resp_err   = rerr_reg;

endmodule
`default_nettype wire
